// File: rtl/tas_if.sv
// Bus bundle for tas_ctrl: the show-ahead FIFO read side plus the RAM write port and status.
// fifo_rd pops the head byte at the clock edge where fifo_rd=1 (implies fifo_empty=0);
// ram_wr_n is low for exactly one cycle per write, with ram_addr/ram_data valid in that cycle.
interface tas_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              ram_wr_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              busy;
    logic              temp_pkt;

    modport master (
        output fifo_empty, fifo_data,
        input  fifo_rd, ram_wr_n, ram_addr, ram_data, busy, temp_pkt
    );

    modport slave (
        input  fifo_empty, fifo_data,
        output fifo_rd, ram_wr_n, ram_addr, ram_data, busy, temp_pkt
    );
endinterface

// File: rtl/tas_ctrl.sv
// Packet sequencer: pops header + NBYTES payload bytes, writes the floor average of
// temperature packets to RAM at a down-counting address, and drops other packets.
module tas_ctrl #(
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 8,
    parameter int                NBYTES     = 4,
    parameter logic [ADDR_W-1:0] ADDR_START = 11'h7FF,
    parameter logic [DATA_W-1:0] HDR_A      = 8'hA5,
    parameter logic [DATA_W-1:0] HDR_B      = 8'hC3
) (
    input  logic       clk_2,
    input  logic       reset_n,
    tas_if.slave       bus,
    output logic [1:0] o_dbg_state
);
    localparam int LOG2N = $clog2(NBYTES);
    localparam int CNT_W = (LOG2N > 0) ? LOG2N : 1;
    localparam int ACC_W = DATA_W + LOG2N;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_WR   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ACC_W-1:0]  r_acc, w_acc_nxt;
    logic              r_temp, w_temp_nxt;
    logic              r_wr_n, w_wr_n_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              w_pop;
    logic [ACC_W-1:0]  w_sum;

    // Reset gates the pop so no byte is lost while the sequencer is held.
    assign w_pop = reset_n & ~bus.fifo_empty & ((r_state == ST_HDR) | (r_state == ST_PAY));
    assign w_sum = r_acc + ACC_W'(bus.fifo_data);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_temp_nxt  = r_temp;
        w_wr_n_nxt  = r_wr_n;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        case (r_state)
            ST_HDR: begin
                if (w_pop) begin
                    w_temp_nxt  = (bus.fifo_data == HDR_A) | (bus.fifo_data == HDR_B);
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                if (w_pop) begin
                    w_acc_nxt = w_sum;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NBYTES - 1)) begin
                        if (r_temp) begin
                            w_data_nxt  = w_sum[LOG2N +: DATA_W];
                            w_wr_n_nxt  = 1'b0;
                            w_state_nxt = ST_WR;
                        end else begin
                            w_state_nxt = ST_HDR;
                        end
                    end
                end
            end
            ST_WR: begin
                w_wr_n_nxt  = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Address steps only after the strobe has risen, keeping it stable around the write.
                w_addr_nxt  = r_addr - 1'b1;
                w_state_nxt = ST_HDR;
            end
            default: w_state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            r_state <= ST_HDR;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_temp  <= 1'b0;
            r_wr_n  <= 1'b1;
            r_addr  <= ADDR_START;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_temp  <= w_temp_nxt;
            r_wr_n  <= w_wr_n_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.fifo_rd  = w_pop;
    assign bus.ram_wr_n = r_wr_n;
    assign bus.ram_addr = r_addr;
    assign bus.ram_data = r_data;
    assign bus.busy     = (r_state != ST_HDR);
    assign bus.temp_pkt = r_temp;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_tas_ctrl.sv
// Bench for tas_ctrl: a FIFO model feeds packets, a packet-level reference model predicts
// every RAM write (address, floor average) and the monitor checks strobes against it.
module tb_tas_ctrl;
    logic       clk_2;
    logic       reset_n;
    logic [1:0] dbg_state;

    tas_if #(.ADDR_W(11), .DATA_W(8)) bus ();

    tas_ctrl dut (
        .clk_2       (clk_2),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    logic [7:0]  fifo_q[$];
    logic [18:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          gap_pct = 0;
    bit          hold_empty = 0;
    int          m_addr = 2047;
    int          strobes = 0;
    int          last_strobe_cyc = -1;
    bit          chk_tput = 0;
    logic        prev_wr_n = 1'b1;
    logic [10:0] prev_addr = 11'h7FF;
    logic [10:0] strobe_addr = 11'h7FF;
    bit          after_strobe = 0;
    logic [7:0]  last_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a whole packet maps to at most one write at the next address.
    task automatic send_pkt(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
        int sum;
        fifo_q.push_back(h);
        fifo_q.push_back(p0);
        fifo_q.push_back(p1);
        fifo_q.push_back(p2);
        fifo_q.push_back(p3);
        if (h == 8'hA5 || h == 8'hC3) begin
            sum = int'(p0) + int'(p1) + int'(p2) + int'(p3);
            exp_q.push_back({11'(m_addr), 8'(sum / 4)});
            m_addr = (m_addr == 0) ? 2047 : m_addr - 1;
        end
    endtask

    task automatic drive_inputs();
        if (!hold_empty && fifo_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            bus.fifo_empty = 1'b0;
            bus.fifo_data  = fifo_q[0];
        end else begin
            bus.fifo_empty = 1'b1;
            bus.fifo_data  = 8'($urandom);
        end
    endtask

    task automatic monitor();
        logic [18:0] e;
        if (!bus.ram_wr_n) begin
            strobes++;
            check("strobe_width", prev_wr_n, 1'b1);
            check("addr_setup", bus.ram_addr, prev_addr);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.ram_addr, e[18:8]);
                check("wr_data", bus.ram_data, e[7:0]);
            end
            if (chk_tput && last_strobe_cyc >= 0)
                check("throughput", cyc - last_strobe_cyc, 7);
            last_strobe_cyc = cyc;
            last_data       = bus.ram_data;
            strobe_addr     = bus.ram_addr;
            after_strobe    = 1;
        end else begin
            if (after_strobe) check("addr_hold", bus.ram_addr, strobe_addr);
            after_strobe = 0;
            check("data_hold", bus.ram_data, last_data);
        end
        prev_wr_n = bus.ram_wr_n;
        prev_addr = bus.ram_addr;
    endtask

    task automatic tick();
        logic rd;
        #1;
        rd = bus.fifo_rd;
        if (bus.fifo_empty || !reset_n) check("rd_gated", rd, 1'b0);
        @(posedge clk_2);
        cyc++;
        if (rd) void'(fifo_q.pop_front());
        @(negedge clk_2);
        monitor();
        drive_inputs();
    endtask

    task automatic set_gap(input bit v);
        hold_empty = v;
        drive_inputs();
    endtask

    task automatic apply_reset(input int n);
        reset_n      = 1'b0;
        after_strobe = 0;
        last_data    = 8'h00;
        repeat (n) begin
            tick();
            check("rst_wr_n", bus.ram_wr_n, 1'b1);
            check("rst_addr", bus.ram_addr, 11'h7FF);
            check("rst_data", bus.ram_data, 8'h00);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_temp", bus.temp_pkt, 1'b0);
            check("rst_state", dbg_state, 2'd0);
        end
        m_addr = 2047;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || bus.busy) && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_timeout", n < max_cyc, 1'b1);
    endtask

    task automatic run_until(input int left);
        int n = 0;
        while (fifo_q.size() > left && n < 1000) begin
            tick();
            n++;
        end
        check("run_timeout", n < 1000, 1'b1);
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (bus.ram_wr_n && n < 100) begin
            tick();
            n++;
        end
        check("strobe_timeout", n < 100, 1'b1);
    endtask

    initial begin
        int s0;
        int t0;
        int qsz;
        logic [7:0] h;
        reset_n        = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        @(negedge clk_2);

        // Reset with a non-empty FIFO: nothing may be popped.
        send_pkt(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04);
        drive_inputs();
        apply_reset(3);
        check("rst_no_pop", fifo_q.size(), 5);
        fifo_q.delete();
        exp_q.delete();
        drive_inputs();

        // Single preloaded packet: 270/4 -> 67 at 7FF, strobe on the 5th pop edge.
        send_pkt(8'hA5, 8'h3A, 8'h55, 8'h43, 8'h3C);
        drive_inputs();
        s0      = strobes;
        t0      = cyc;
        reset_n = 1'b1;
        wait_strobe();
        check("first_latency", last_strobe_cyc - t0, 5);
        drain(50);
        check("single_count", strobes - s0, 1);
        check("next_addr", bus.ram_addr, 11'h7FE);

        // Dark-side gaps mid-packet and before the last byte.
        apply_reset(2);
        reset_n = 1'b1;
        send_pkt(8'hA5, 8'h02, 8'h04, 8'h06, 8'h08);
        send_pkt(8'hC3, 8'h0A, 8'h0C, 8'h0E, 8'h10);
        run_until(6);
        set_gap(1);
        qsz = fifo_q.size();
        repeat (50) tick();
        check("gap_no_pop", fifo_q.size(), qsz);
        check("gap_busy", bus.busy, 1'b1);
        check("gap_temp", bus.temp_pkt, 1'b1);
        set_gap(0);
        run_until(1);
        set_gap(1);
        repeat (20) tick();
        check("gap2_busy", bus.busy, 1'b1);
        check("gap2_pending", exp_q.size(), 1);
        set_gap(0);
        drain(100);

        // Non-temp packet whose payload looks like headers, then a temp packet.
        s0 = strobes;
        send_pkt(8'h83, 8'hA5, 8'hC3, 8'hA5, 8'hC3);
        send_pkt(8'hA5, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        run_until(7);
        set_gap(1);
        repeat (3) tick();
        check("nontemp_flag", bus.temp_pkt, 1'b0);
        check("nontemp_busy", bus.busy, 1'b1);
        set_gap(0);
        drain(100);
        check("nontemp_count", strobes - s0, 1);

        // Randomized packets and gaps.
        gap_pct = 30;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(2))
                0:       h = 8'hA5;
                1:       h = 8'hC3;
                default: h = 8'($urandom);
            endcase
            send_pkt(h, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        drain(150 * 5 * 4 + 200);
        gap_pct = 0;

        // Address wrap with back-to-back packets: 7 cycles per write.
        apply_reset(2);
        reset_n = 1'b1;
        for (int i = 0; i < 2048; i++) send_pkt(8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drive_inputs();
        s0              = strobes;
        chk_tput        = 1;
        last_strobe_cyc = -1;
        drain(2048 * 7 + 200);
        chk_tput = 0;
        check("wrap_count", strobes - s0, 2048);
        check("wrap_addr", bus.ram_addr, 11'h7FF);

        // Reset while the strobe is low: no repeat, address reloads.
        apply_reset(2);
        reset_n = 1'b1;
        send_pkt(8'hA5, 8'h10, 8'h20, 8'h30, 8'h40);
        drive_inputs();
        wait_strobe();
        s0 = strobes;
        apply_reset(2);
        reset_n = 1'b1;
        repeat (10) tick();
        check("no_repeat", strobes - s0, 0);
        send_pkt(8'hA5, 8'h0A, 8'h14, 8'h1E, 8'h28);
        drain(100);
        check("post_rst_count", strobes - s0, 1);
        check("post_rst_addr", bus.ram_addr, 11'h7FE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
